s_mem_sequencer: RTL

- Owns the single-port S memory (256x8) and shares it across the three RC4 phases in order: init (s[i]=i), shuffle (KSA swap) and decrypt (PRGA/XOR).
- Replaces the ad-hoc done-flag priority mux at the top level.
- Starts each phase, grants memory access only to the owning client, registers the memory controls and routes tagged read-valid pulses back to the owner.
- Supports abort/restart on key change and a per-phase watchdog.

---
 rtl/s_mem_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/s_mem_sequencer.sv
// Sequences the RC4 init/shuffle/decrypt phases over one shared 256x8 S memory.
// Memory controls are registered one cycle after grant and read valid returns 1+RD_LATENCY cycles after grant; there is no queueing, so a non-owner holds req until its phase.
module s_mem_sequencer #(
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = 13
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       go,
    input  logic       restart,
    output logic       init_start,
    output logic       shuf_start,
    output logic       dec_start,
    input  logic       init_done,
    input  logic       shuf_done,
    input  logic       dec_done,
    input  logic       init_req,
    input  logic       shuf_req,
    input  logic       dec_req,
    input  logic [7:0] init_addr,
    input  logic [7:0] shuf_addr,
    input  logic [7:0] dec_addr,
    input  logic [7:0] init_wdata,
    input  logic [7:0] shuf_wdata,
    input  logic [7:0] dec_wdata,
    input  logic       init_wren,
    input  logic       shuf_wren,
    input  logic       dec_wren,
    output logic       init_gnt,
    output logic       shuf_gnt,
    output logic       dec_gnt,
    output logic       init_rvalid,
    output logic       shuf_rvalid,
    output logic       dec_rvalid,
    output logic [7:0] rdata,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [2:0] phase,
    output logic       busy,
    output logic       all_done,
    output logic       error
);

    localparam int PIPE_D = 1 + RD_LATENCY;

    typedef enum logic [2:0] {IDLE, RUN_INIT, RUN_SHUF, RUN_DEC, COMPLETE} state_t;

    state_t                    state;
    logic [TO_WIDTH-1:0]       wd_cnt;
    logic [PIPE_D-1:0][2:0]    rd_pipe;

    logic       running;
    logic       own_done;
    logic       wd_hit;
    logic       timeout_now;
    logic [2:0] gnt_tag;
    logic       any_gnt;
    logic [7:0] g_addr;
    logic [7:0] g_wdata;
    logic       g_wren;

    assign init_gnt = init_req && (state == RUN_INIT);
    assign shuf_gnt = shuf_req && (state == RUN_SHUF);
    assign dec_gnt  = dec_req  && (state == RUN_DEC);
    assign gnt_tag  = {dec_gnt, shuf_gnt, init_gnt};
    assign any_gnt  = |gnt_tag;

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_wren  = 1'b0;
        if (init_gnt) begin
            g_addr  = init_addr;
            g_wdata = init_wdata;
            g_wren  = init_wren;
        end else if (shuf_gnt) begin
            g_addr  = shuf_addr;
            g_wdata = shuf_wdata;
            g_wren  = shuf_wren;
        end else if (dec_gnt) begin
            g_addr  = dec_addr;
            g_wdata = dec_wdata;
            g_wren  = dec_wren;
        end
    end

    always_comb begin
        own_done = 1'b0;
        case (state)
            RUN_INIT: own_done = init_done;
            RUN_SHUF: own_done = shuf_done;
            RUN_DEC:  own_done = dec_done;
            default:  own_done = 1'b0;
        endcase
    end

    assign running     = (state == RUN_INIT) || (state == RUN_SHUF) || (state == RUN_DEC);
    // The counter reaching TIMEOUT_CYCLES-1 on this edge is the timeout; a done in the same cycle wins.
    assign wd_hit      = (wd_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 2));
    assign timeout_now = running && !own_done && wd_hit;

    assign {dec_rvalid, shuf_rvalid, init_rvalid} = rd_pipe[PIPE_D-1];
    assign rdata = s_q;

    // Read tags are captured at issue, so a phase change never reroutes an in-flight read.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s_addr  <= '0;
            s_wdata <= '0;
            s_wren  <= 1'b0;
            rd_pipe <= '0;
        end else if (restart) begin
            s_wren  <= 1'b0;
            rd_pipe <= '0;
        end else begin
            for (int i = PIPE_D - 1; i > 0; i--) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            rd_pipe[0] <= g_wren ? 3'b000 : gnt_tag;
            if (any_gnt) begin
                s_addr  <= g_addr;
                s_wdata <= g_wdata;
            end
            s_wren <= g_wren && !timeout_now;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wd_cnt     <= '0;
            init_start <= 1'b0;
            shuf_start <= 1'b0;
            dec_start  <= 1'b0;
            phase      <= 3'b000;
            busy       <= 1'b0;
            all_done   <= 1'b0;
            error      <= 1'b0;
        end else begin
            init_start <= 1'b0;
            shuf_start <= 1'b0;
            dec_start  <= 1'b0;
            if (restart) begin
                state    <= IDLE;
                wd_cnt   <= '0;
                phase    <= 3'b000;
                busy     <= 1'b0;
                all_done <= 1'b0;
                error    <= 1'b0;
            end else begin
                case (state)
                    // A latched watchdog error parks the sequencer until restart.
                    IDLE: begin
                        if (go && !error) begin
                            state      <= RUN_INIT;
                            init_start <= 1'b1;
                            phase      <= 3'b001;
                            busy       <= 1'b1;
                            wd_cnt     <= '0;
                        end
                    end
                    RUN_INIT, RUN_SHUF, RUN_DEC: begin
                        if (own_done) begin
                            wd_cnt <= '0;
                            case (state)
                                RUN_INIT: begin
                                    state      <= RUN_SHUF;
                                    shuf_start <= 1'b1;
                                    phase      <= 3'b010;
                                end
                                RUN_SHUF: begin
                                    state     <= RUN_DEC;
                                    dec_start <= 1'b1;
                                    phase     <= 3'b100;
                                end
                                default: begin
                                    state    <= COMPLETE;
                                    phase    <= 3'b000;
                                    busy     <= 1'b0;
                                    all_done <= 1'b1;
                                end
                            endcase
                        end else if (wd_hit) begin
                            state  <= IDLE;
                            error  <= 1'b1;
                            phase  <= 3'b000;
                            busy   <= 1'b0;
                            wd_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + TO_WIDTH'(1);
                        end
                    end
                    COMPLETE: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
